// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives Start/A/B, observes Busy/Done/Diff/Borrow(/Overflow)
//   slave  : the subtractor side
//   Signals:
//     Start    request, sampled only while Busy=0
//     A, B     minuend / subtrahend, sampled on the accepted-Start edge
//     Busy     high while bits are being shifted
//     Done     one-cycle pulse, result valid
//     Diff     (A - B) mod 2^WIDTH
//     Borrow   1 iff A < B (unsigned)
//     Overflow signed overflow flag, present only when SUB_OVERFLOW_EN is defined
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Diff;
   logic             Borrow;
`ifdef SUB_OVERFLOW_EN
   logic             Overflow;
`endif

   modport master (
      output Start, A, B,
      input  Busy, Done, Diff, Borrow
`ifdef SUB_OVERFLOW_EN
      , input Overflow
`endif
   );

   modport slave (
      input  Start, A, B,
      output Busy, Done, Diff, Borrow
`ifdef SUB_OVERFLOW_EN
      , output Overflow
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor, Diff = A - B, one bit per clock,
//   LSB first. Start/Busy/Done handshake; Diff/Borrow(/Overflow) are loaded
//   when the FSM enters DONE and held until the next result or reset.
//   Latency: Start accepted at edge N -> Busy cycles N+1..N+WIDTH,
//   Done in cycle N+WIDTH+1. Back-to-back Start in DONE gives one result
//   every WIDTH+1 cycles.
// Ports:
//   Clk    rising-edge clock
//   Rst_n  synchronous reset, active low
//   bus    serial_subtractor_if.slave (Start, A, B, Busy, Done, Diff, Borrow,
//          Overflow when enabled)
// Configuration:
//   SUB_OVERFLOW_EN  when defined, adds the signed Overflow flag and the two
//                    operand-MSB registers it needs.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   serial_subtractor_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   // Collected difference bits; the final bit is merged in on DONE entry, so
   // only WIDTH-1 bits need storing here.
   logic [WIDTH-2:0] res_q,    res_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             bf_q,     bf_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
`ifdef SUB_OVERFLOW_EN
   logic             a_msb_q,  a_msb_d;
   logic             b_msb_q,  b_msb_d;
   logic             ovf_q,    ovf_d;
`endif

   // Full subtractor built from two half subtractors.
   logic hs_x, hs_b1, hs_b2, bit_d, bf_next;
   assign hs_x    = a_q[0] ^ b_q[0];
   assign hs_b1   = ~a_q[0] & b_q[0];
   assign bit_d   = hs_x ^ bf_q;
   assign hs_b2   = ~hs_x & bf_q;
   assign bf_next = hs_b1 | hs_b2;

   logic [WIDTH-1:0] diff_final;
   assign diff_final = {bit_d, res_q};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      bf_d     = bf_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
`ifdef SUB_OVERFLOW_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.Start) begin
               state_d = SHIFT;
               a_d     = bus.A;
               b_d     = bus.B;
               bf_d    = 1'b0;
               cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
               a_msb_d = bus.A[WIDTH-1];
               b_msb_d = bus.B[WIDTH-1];
`endif
            end
         end
         SHIFT: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            // New bit enters at the top; the oldest falls off bit 0.
            res_d = (WIDTH-1)'({bit_d, res_q} >> 1);
            bf_d  = bf_next;
            if (cnt_q == CW'(WIDTH-1)) begin
               // Last bit: counter holds rather than wrapping.
               state_d  = DONE;
               diff_d   = diff_final;
               borrow_d = bf_next;
`ifdef SUB_OVERFLOW_EN
               ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_final[WIDTH-1]);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         bf_q     <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
`ifdef SUB_OVERFLOW_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         bf_q     <= bf_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
`ifdef SUB_OVERFLOW_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.Busy   = (state_q == SHIFT);
   assign bus.Done   = (state_q == DONE);
   assign bus.Diff   = diff_q;
   assign bus.Borrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
   assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=4 and WIDTH=8.
//   Expected results come from integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   serial_subtractor_if #(.WIDTH(4)) if4 ();
   serial_subtractor_if #(.WIDTH(8)) if8 ();

   serial_subtractor #(.WIDTH(4)) u_dut4 (.Clk(clk), .Rst_n(rst_n), .bus(if4.slave));
   serial_subtractor #(.WIDTH(8)) u_dut8 (.Clk(clk), .Rst_n(rst_n), .bus(if8.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_diff(input int a, input int b, input int w);
      return (a - b) & ((1 << w) - 1);
   endfunction

   function automatic int ref_borrow(input int a, input int b);
      return (a < b) ? 1 : 0;
   endfunction

   function automatic int ref_ovf(input int a, input int b, input int w);
      int sa, sb, r;
      sa = (a >= (1 << (w-1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w-1))) ? b - (1 << w) : b;
      r  = sa - sb;
      return (r < -(1 << (w-1)) || r > (1 << (w-1)) - 1) ? 1 : 0;
   endfunction

   // One WIDTH=4 operation with cycle-exact handshake checks.
   task automatic run4(input int a, input int b);
      @(negedge clk);
      if4.Start = 1'b1;
      if4.A     = 4'(a);
      if4.B     = 4'(b);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("busy_shift", 32'(if4.Busy), 32'd1);
         chk("done_shift", 32'(if4.Done), 32'd0);
         if4.Start = 1'b0;
         if4.A     = 4'($urandom);
         if4.B     = 4'($urandom);
      end
      @(negedge clk);
      chk("done_pulse", 32'(if4.Done), 32'd1);
      chk("busy_done",  32'(if4.Busy), 32'd0);
      chk("diff",       32'(if4.Diff), 32'(ref_diff(a, b, 4)));
      chk("borrow",     32'(if4.Borrow), 32'(ref_borrow(a, b)));
`ifdef SUB_OVERFLOW_EN
      chk("ovf",        32'(if4.Overflow), 32'(ref_ovf(a, b, 4)));
`endif
      @(negedge clk);
      chk("done_single", 32'(if4.Done), 32'd0);
      chk("diff_hold",   32'(if4.Diff), 32'(ref_diff(a, b, 4)));
   endtask

   // WIDTH=8 random stream with Start held high; results checked from a queue.
   task automatic rand8(input int n);
      int qa[$];
      int qb[$];
      int pushed = 0, got = 0, cyc = 0, last_done = -1;
      int a, b, ea, eb;
      if8.Start = 1'b0;
      while (got < n && cyc < n * 9 + 100) begin
         @(negedge clk);
         cyc++;
         if (if8.Done) begin
            if (qa.size() == 0) begin
               chk("rnd_unexpected_done", 32'd1, 32'd0);
            end else begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               chk("rnd_diff",   32'(if8.Diff),   32'(ref_diff(ea, eb, 8)));
               chk("rnd_borrow", 32'(if8.Borrow), 32'(ref_borrow(ea, eb)));
`ifdef SUB_OVERFLOW_EN
               chk("rnd_ovf",    32'(if8.Overflow), 32'(ref_ovf(ea, eb, 8)));
`endif
            end
            if (last_done >= 0) chk("rnd_gap", 32'(cyc - last_done), 32'd9);
            last_done = cyc;
            got++;
         end
         if (!if8.Busy) begin
            if (pushed < n) begin
               a = int'($urandom_range(0, 255));
               b = int'($urandom_range(0, 255));
               if8.A     = 8'(a);
               if8.B     = 8'(b);
               if8.Start = 1'b1;
               qa.push_back(a);
               qb.push_back(b);
               pushed++;
            end else begin
               if8.Start = 1'b0;
            end
         end else begin
            if8.A = 8'($urandom);
            if8.B = 8'($urandom);
         end
      end
      if (got < n) chk("rnd_timeout", 32'(got), 32'(n));
      if8.Start = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      if4.Start = 1'b0; if4.A = '0; if4.B = '0;
      if8.Start = 1'b0; if8.A = '0; if8.B = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",   32'(if4.Busy),   32'd0);
      chk("rst_done",   32'(if4.Done),   32'd0);
      chk("rst_diff",   32'(if4.Diff),   32'd0);
      chk("rst_borrow", 32'(if4.Borrow), 32'd0);
`ifdef SUB_OVERFLOW_EN
      chk("rst_ovf",    32'(if4.Overflow), 32'd0);
`endif
      rst_n = 1'b1;

      // Basic and boundary operands.
      run4(9, 3);
      run4(3, 9);
      run4(0, 1);
      run4(0, 0);
      run4(15, 15);
      run4(15, 0);

      // Start held high: a result every 5 cycles, mid-SHIFT operand noise.
      @(negedge clk);
      if4.Start = 1'b1; if4.A = 4'd5; if4.B = 4'd2;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         chk("b2b_busy", 32'(if4.Busy), 32'((c % 5) != 0));
         chk("b2b_done", 32'(if4.Done), 32'((c % 5) == 0));
         if (if4.Done) begin
            chk("b2b_diff",   32'(if4.Diff),   32'd3);
            chk("b2b_borrow", 32'(if4.Borrow), 32'd0);
         end
         if (if4.Busy) begin
            if4.A = 4'($urandom);
            if4.B = 4'($urandom);
         end else begin
            if4.A = 4'd5;
            if4.B = 4'd2;
         end
         if (c == 15) if4.Start = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle", 32'(if4.Busy), 32'd0);

      // Reset in the second SHIFT cycle discards the operation.
      @(negedge clk);
      if4.Start = 1'b1; if4.A = 4'd9; if4.B = 4'd3;
      @(negedge clk);
      if4.Start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy",   32'(if4.Busy),   32'd0);
      chk("mid_rst_done",   32'(if4.Done),   32'd0);
      chk("mid_rst_diff",   32'(if4.Diff),   32'd0);
      chk("mid_rst_borrow", 32'(if4.Borrow), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("mid_rst_no_done", 32'(if4.Done), 32'd0);
      end
      run4(7, 2);

      // Signed overflow corner cases (Overflow checked when enabled).
      run4(8, 1);
      run4(7, 1);
      run4(7, 8);

      rand8(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
